load_store_unit: RTL and testbench

// Initiator that drives the word-wide Data_Memory port on behalf of the core.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide, async-read data memory.
// Word-aligns addresses, extracts/extends sub-word loads and performs SB/SH by read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit RMW_SUBWORD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_s;
  logic        accept_s, err_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  lane_r;
  logic [15:0] wdata_r;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (we) begin
      case (f3)
        3'b000:  e = (RMW_SUBWORD == 1'b0);
        3'b001:  e = a[0] | (RMW_SUBWORD == 1'b0);
        3'b010:  e = (a != 2'b00);
        default: e = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: e = 1'b0;
        3'b001, 3'b101: e = a[0];
        3'b010:         e = (a != 2'b00);
        default:        e = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half lane of the word just read.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000: begin
        case (a)
          2'b00:   r[7:0]   = d[7:0];
          2'b01:   r[15:8]  = d[7:0];
          2'b10:   r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      3'b001: begin
        if (a[1]) r[31:16] = d;
        else      r[15:0]  = d;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_ready = (state_r == IDLE) && !rst;

  // Next-state decode and request classification.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    err_s    = access_err(req_we, req_funct3, req_addr[1:0]);
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (err_s)                               state_s = RESP;
          else if (req_we && req_funct3 == 3'b010) state_s = WR;
          else                                     state_s = RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD:      state_s = we_r ? WR : RESP;
      WR:      state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and registered memory/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      funct3_r   <= 3'd0;
      lane_r     <= 2'd0;
      wdata_r    <= 16'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      mem_we     <= (state_s == WR);
      resp_valid <= (state_s == RESP);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r       <= req_we;
            funct3_r   <= req_funct3;
            lane_r     <= req_addr[1:0];
            wdata_r    <= req_wdata[15:0];
            resp_err   <= err_s;
            resp_rdata <= 32'd0;
            if (!err_s) begin
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= req_wdata;
            end
          end
        end
        RD: begin
          if (we_r) mem_wdata  <= store_merge(funct3_r, lane_r, mem_rdata, wdata_r);
          else      resp_rdata <= load_extract(funct3_r, lane_r, mem_rdata);
        end
        WR:      resp_rdata <= 32'd0;
        RESP: begin
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: resp_err <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 16-word data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wcnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          wr0;
    int          nwr;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.ADDR_WIDTH(32), .RMW_SUBWORD(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("write_count", wcnt - e.wr0, e.nwr);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int lat, input int nwr);
    int n;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 32'd1, 32'd0);
    e.err = err; e.rdata = rdata; e.lat = lat; e.acc = cyc + 1; e.wr0 = wcnt; e.nwr = nwr;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int accepts;
    int w_before;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h0, 32'hAABBCCDD, 1'b0, 32'h0, 2, 1);
    chk("mem0_sw", mem[0], 32'hAABBCCDD);
    issue(1'b0, 3'b000, 32'h1, 32'h0, 1'b0, 32'hFFFFFFCC, 2, 0);
    issue(1'b0, 3'b100, 32'h1, 32'h0, 1'b0, 32'h000000CC, 2, 0);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'hAABBCCDD, 2, 0);

    issue(1'b1, 3'b000, 32'h2, 32'h00000011, 1'b0, 32'h0, 3, 1);
    chk("mem0_sb", mem[0], 32'hAA11CCDD);
    issue(1'b0, 3'b001, 32'h2, 32'h0, 1'b0, 32'hFFFFAA11, 2, 0);
    issue(1'b0, 3'b101, 32'h2, 32'h0, 1'b0, 32'h0000AA11, 2, 0);
    issue(1'b0, 3'b001, 32'h0, 32'h0, 1'b0, 32'hFFFFCCDD, 2, 0);

    issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b1, 32'h0, 1, 0);
    issue(1'b1, 3'b001, 32'h3, 32'h12345678, 1'b1, 32'h0, 1, 0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0);
    issue(1'b1, 3'b100, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0);
    issue(1'b1, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0, 1, 0);
    chk("mem0_after_err", mem[0], 32'hAA11CCDD);

    issue(1'b1, 3'b001, 32'h4, 32'h1234BEEF, 1'b0, 32'h0, 3, 1);
    chk("mem1_sh_lo", mem[1], 32'h0000BEEF);
    issue(1'b1, 3'b001, 32'h6, 32'h0000CAFE, 1'b0, 32'h0, 3, 1);
    chk("mem1_sh_hi", mem[1], 32'hCAFEBEEF);
    issue(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 32'hFFFFFFCA, 2, 0);
    issue(1'b0, 3'b100, 32'h4, 32'h0, 1'b0, 32'h000000EF, 2, 0);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'hCAFEBEEF, 2, 0);

    // Reset during the read phase of an SB must abort it without a write.
    w_before = wcnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h55;
    chk("ready_before_abort", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", wcnt - w_before, 32'd0);
    chk("abort_mem0", mem[0], 32'hAA11CCDD);

    // Back-to-back: request held valid, only IDLE cycles accept.
    accepts = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
    for (int k = 0; k < 9; k++) begin
      if (req_ready) begin
        exp_t e;
        e.err = 1'b0; e.rdata = 32'hAA11CCDD; e.lat = 2; e.acc = cyc + 1; e.wr0 = wcnt; e.nwr = 0;
        sb.push_back(e);
        accepts++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("b2b_resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    chk("b2b_accepts", accepts, 32'd3);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Write strobe must only ever target an aligned word.
  always @(posedge clk) begin
    if (!rst && mem_we && mem_addr[1:0] != 2'b00) chk("unaligned_write", {30'd0, mem_addr[1:0]}, 32'd0);
  end

endmodule
